// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity modes
// and the layout of one FIFO entry ({parity_err, frame_err, data}).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int ENTRY_ERR_BITS = 2;

  function automatic int entry_width(input int data_bits);
    return data_bits + ENTRY_ERR_BITS;
  endfunction

  function automatic int frame_err_pos(input int data_bits);
    return data_bits;
  endfunction

  function automatic int parity_err_pos(input int data_bits);
    return data_bits + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (level_r == LW'(DEPTH));
  assign empty   = (level_r == {LW{1'b0}});
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];

  assign do_rd_s = rd_en & ~empty & ~clear;
  assign do_wr_s = wr_en & ~clear & (~full | do_rd_s);

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// Parametrised UART receiver: synchroniser, bit-timing FSM, parity/framing
// checks, byte FIFO with valid/ready output and drop/receive accounting.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          clear,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  output logic [15:0]                   rx_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = entry_width(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_INV  = (PARITY == PAR_ODD);

  logic                 rxd_meta_r;
  logic                 rxd_sync_r;
  logic                 rxd_prev_r;
  rx_state_t            state_r;
  rx_state_t            state_n;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_n;
  logic [BW-1:0]        bit_idx_r;
  logic [BW-1:0]        bit_idx_n;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] shreg_n;
  logic                 par_err_r;
  logic                 par_err_n;
  logic                 push_s;
  logic                 frame_err_s;
  logic                 start_edge_s;
  logic                 tick_s;
  logic                 pop_s;
  logic                 wr_en_s;
  logic                 drop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [EW-1:0]        head_s;
  logic                 busy_r;
  logic                 overflow_r;
  logic [7:0]           drop_cnt_r;
  logic [15:0]          rx_cnt_r;

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // A held-low line after a framing error produces no edge, so IDLE waits for 1 then 0
  assign start_edge_s = rxd_prev_r & ~rxd_sync_r;
  assign tick_s       = (cnt_r == {CW{1'b0}});

  // FSM and datapath state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      shreg_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_idx_r <= bit_idx_n;
      shreg_r   <= shreg_n;
      par_err_r <= par_err_n;
    end
  end

  // Next-state, sampling and push decode
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    bit_idx_n   = bit_idx_r;
    shreg_n     = shreg_r;
    par_err_n   = par_err_r;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          cnt_n     = CNT_HALF;
          par_err_n = 1'b0;
          state_n   = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          cnt_n = cnt_r - CW'(1);
        end else if (rxd_sync_r) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n     = CNT_FULL;
          bit_idx_n = {BW{1'b0}};
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          cnt_n = cnt_r - CW'(1);
        end else begin
          shreg_n   = {rxd_sync_r, shreg_r[DATA_BITS-1:1]};
          cnt_n     = CNT_FULL;
          bit_idx_n = bit_idx_r + BW'(1);
          if (bit_idx_r == LAST_BIT) begin
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_PARITY: begin
        if (!tick_s) begin
          cnt_n = cnt_r - CW'(1);
        end else begin
          par_err_n = (^{shreg_r, rxd_sync_r}) ^ PAR_INV;
          cnt_n     = CNT_FULL;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          cnt_n = cnt_r - CW'(1);
        end else begin
          frame_err_s = ~rxd_sync_r;
          push_s      = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign pop_s   = ~empty_s & m_ready;
  assign wr_en_s = push_s & ~clear & (~full_s | pop_s);
  assign drop_s  = push_s & ~clear & full_s & ~pop_s;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (wr_en_s),
    .wr_data ({par_err_r, frame_err_s, shreg_r}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .level   (level),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Status and accounting registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
      rx_cnt_r   <= 16'd0;
    end else begin
      busy_r <= (state_n != ST_IDLE);
      if (wr_en_s) begin
        rx_cnt_r <= rx_cnt_r + 16'd1;
      end
      if (clear) begin
        overflow_r <= 1'b0;
        drop_cnt_r <= 8'd0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
    end
  end

  // Head fields are forced to zero while the FIFO is empty
  assign m_valid      = ~empty_s;
  assign m_data       = m_valid ? head_s[DATA_BITS-1:0] : {DATA_BITS{1'b0}};
  assign m_frame_err  = m_valid & head_s[frame_err_pos(DATA_BITS)];
  assign m_parity_err = m_valid & head_s[parity_err_pos(DATA_BITS)];
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign drop_cnt     = drop_cnt_r;
  assign rx_cnt       = rx_cnt_r;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: a default-parameter instance (8N1, 217 clk/bit) and a
// small even-parity, 4-deep instance (16 clk/bit), checked against a frame-level model.
module tb_uart_rx_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rxd_a, clear_a, m_ready_a;
  logic        m_valid_a, m_frame_err_a, m_parity_err_a, busy_a, overflow_a;
  logic [7:0]  m_data_a, drop_cnt_a;
  logic [4:0]  level_a;
  logic [15:0] rx_cnt_a;

  logic        rst_n_b, rxd_b, clear_b, m_ready_b;
  logic        m_valid_b, m_frame_err_b, m_parity_err_b, busy_b, overflow_b;
  logic [7:0]  m_data_b, drop_cnt_b;
  logic [2:0]  level_b;
  logic [15:0] rx_cnt_b;

  uart_rx_capture #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .rxd(rxd_a), .clear(clear_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .m_frame_err(m_frame_err_a), .m_parity_err(m_parity_err_a), .busy(busy_a),
    .level(level_a), .overflow(overflow_a), .drop_cnt(drop_cnt_a), .rx_cnt(rx_cnt_a)
  );

  uart_rx_capture #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rxd(rxd_b), .clear(clear_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_frame_err(m_frame_err_b), .m_parity_err(m_parity_err_b), .busy(busy_b),
    .level(level_b), .overflow(overflow_b), .drop_cnt(drop_cnt_b), .rx_cnt(rx_cnt_b)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [9:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

  // Record every accepted head entry as {parity_err, frame_err, data}
  always @(negedge clk) begin
    if (rst_n_a && m_valid_a && m_ready_a) got_a.push_back({m_parity_err_a, m_frame_err_a, m_data_a});
    if (rst_n_b && m_valid_b && m_ready_b) got_b.push_back({m_parity_err_b, m_frame_err_b, m_data_b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the frame as transmitted: par_mode 0 none, 1 odd, 2 even
  function automatic logic [9:0] ref_entry(input logic [7:0] d, input int par_mode,
                                           input logic pb, input logic stop);
    int ones;
    logic perr;
    ones = $countones(d) + int'(pb);
    if (par_mode == 0) perr = 1'b0;
    else if (par_mode == 1) perr = ((ones % 2) != 1);
    else perr = ((ones % 2) != 0);
    return {perr, ~stop, d};
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else rxd_b = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_line(which, v);
    wait_cycles((which == 0) ? 217 : 16);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pb, input logic stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, pb);
    drive_bit(which, stop);
    drive_bit(which, 1'b1);
    drive_bit(which, 1'b1);
  endtask

  task automatic cmp_queue(input int which, input string tag);
    if (which == 0) begin
      check({tag, "_count"}, got_a.size(), exp_a.size());
      while (got_a.size() > 0 && exp_a.size() > 0) check(tag, got_a.pop_front(), exp_a.pop_front());
      got_a.delete();
      exp_a.delete();
    end else begin
      check({tag, "_count"}, got_b.size(), exp_b.size());
      while (got_b.size() > 0 && exp_b.size() > 0) check(tag, got_b.pop_front(), exp_b.pop_front());
      got_b.delete();
      exp_b.delete();
    end
  endtask

  initial begin
    string s;
    logic [7:0] d;
    logic pb, stop;
    int n_a, n_b;

    rst_n_a = 1'b0; rst_n_b = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1;
    clear_a = 1'b0; clear_b = 1'b0; m_ready_a = 1'b1; m_ready_b = 1'b1;
    wait_cycles(3);
    check("rst_valid", m_valid_a, 32'd0);
    check("rst_data", m_data_a, 32'd0);
    check("rst_level", level_a, 32'd0);
    check("rst_busy", busy_a, 32'd0);
    check("rst_ovf", overflow_a, 32'd0);
    check("rst_drop", drop_cnt_a, 32'd0);
    check("rst_rxcnt", rx_cnt_a, 32'd0);
    check("rst_level_b", level_b, 32'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    wait_cycles(4);

    // ASCII string at 217 clk/bit
    s = "I1I2DN";
    for (int i = 0; i < s.len(); i++) begin
      send_frame(0, s[i], 1'b0, 1'b1);
      exp_a.push_back(ref_entry(s[i], 0, 1'b0, 1'b1));
    end
    wait_cycles(5);
    cmp_queue(0, "ascii");
    check("ascii_rxcnt", rx_cnt_a, 32'd6);
    n_a = 6;

    // Short low pulse is rejected at the mid-start sample
    set_line(0, 1'b0);
    wait_cycles(20);
    check("glitch_busy_hi", busy_a, 32'd1);
    wait_cycles(20);
    set_line(0, 1'b1);
    wait_cycles(100);
    check("glitch_busy_lo", busy_a, 32'd0);
    check("glitch_level", level_a, 32'd0);
    check("glitch_rxcnt", rx_cnt_a, 32'd6);
    check("glitch_nopush", got_a.size(), 32'd0);

    // Framing error then a clean frame
    send_frame(0, 8'h55, 1'b0, 1'b0);
    exp_a.push_back(ref_entry(8'h55, 0, 1'b0, 1'b0));
    send_frame(0, 8'hA3, 1'b0, 1'b1);
    exp_a.push_back(ref_entry(8'hA3, 0, 1'b0, 1'b1));
    wait_cycles(5);
    cmp_queue(0, "frame_err");
    n_a += 2;

    // Random bytes, occasional bad stop bit
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 1'b0, stop);
      exp_a.push_back(ref_entry(d, 0, 1'b0, stop));
    end
    wait_cycles(5);
    cmp_queue(0, "rand_a");
    n_a += 6;
    check("rand_a_rxcnt", rx_cnt_a, 32'(n_a));

    // Even parity: correct and wrong parity bit on 0x31
    send_frame(1, 8'h31, 1'b1, 1'b1);
    exp_b.push_back(ref_entry(8'h31, 2, 1'b1, 1'b1));
    send_frame(1, 8'h31, 1'b0, 1'b1);
    exp_b.push_back(ref_entry(8'h31, 2, 1'b0, 1'b1));
    wait_cycles(3);
    cmp_queue(1, "parity");
    n_b = 2;

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(1, d, pb, stop);
      exp_b.push_back(ref_entry(d, 2, pb, stop));
    end
    wait_cycles(3);
    cmp_queue(1, "rand_b");
    n_b += 8;
    check("rand_b_rxcnt", rx_cnt_b, 32'(n_b));

    // Overflow: six bytes into a 4-deep FIFO with no consumer
    m_ready_b = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      d = 8'(k);
      send_frame(1, d, ^d, 1'b1);
      if (k <= 4) exp_b.push_back(ref_entry(d, 2, ^d, 1'b1));
    end
    n_b += 4;
    check("ovf_level", level_b, 32'd4);
    check("ovf_flag", overflow_b, 32'd1);
    check("ovf_drop", drop_cnt_b, 32'd2);
    check("ovf_rxcnt", rx_cnt_b, 32'(n_b));
    m_ready_b = 1'b1;
    wait_cycles(8);
    cmp_queue(1, "ovf_drain");
    check("ovf_sticky", overflow_b, 32'd1);

    clear_b = 1'b1;
    wait_cycles(1);
    clear_b = 1'b0;
    check("clr_ovf", overflow_b, 32'd0);
    check("clr_drop", drop_cnt_b, 32'd0);
    check("clr_rxcnt", rx_cnt_b, 32'(n_b));

    // Full FIFO: pop coincides with the stop-bit push (sample 10 lands 171 clocks after the start edge is driven)
    m_ready_b = 1'b0;
    for (int k = 8'h11; k <= 8'h14; k++) begin
      d = 8'(k);
      send_frame(1, d, ^d, 1'b1);
      exp_b.push_back(ref_entry(d, 2, ^d, 1'b1));
    end
    check("full_level", level_b, 32'd4);
    fork
      send_frame(1, 8'h15, 1'b1, 1'b1);
      begin
        wait_cycles(170);
        m_ready_b = 1'b1;
        wait_cycles(1);
        m_ready_b = 1'b0;
      end
    join
    exp_b.push_back(ref_entry(8'h15, 2, 1'b1, 1'b1));
    n_b += 5;
    check("pp_level", level_b, 32'd4);
    check("pp_drop", drop_cnt_b, 32'd0);
    check("pp_popped", got_b.size(), 32'd1);
    m_ready_b = 1'b1;
    wait_cycles(8);
    cmp_queue(1, "pp_drain");
    check("pp_rxcnt", rx_cnt_b, 32'(n_b));

    // Reset mid-data of 0x7E discards the partial byte
    drive_bit(1, 1'b0);
    drive_bit(1, 1'b0);
    drive_bit(1, 1'b1);
    drive_bit(1, 1'b1);
    rst_n_b = 1'b0;
    wait_cycles(1);
    rst_n_b = 1'b1;
    set_line(1, 1'b1);
    wait_cycles(60);
    check("rstmid_busy", busy_b, 32'd0);
    check("rstmid_rxcnt", rx_cnt_b, 32'd0);
    check("rstmid_nopush", got_b.size(), 32'd0);
    send_frame(1, 8'h42, 1'b0, 1'b1);
    exp_b.push_back(ref_entry(8'h42, 2, 1'b0, 1'b1));
    wait_cycles(3);
    cmp_queue(1, "after_rst");
    check("after_rst_rxcnt", rx_cnt_b, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
